// File: rtl/simple_processor_pkg.sv
// Shared decode types and widths for the simple processor datapath.
package simple_processor_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned IMM_WIDTH          = 6;
  localparam int unsigned SHAMT_WIDTH        = 5;

  // Decoded function code; codes 11..15 are undefined.
  typedef enum logic [3:0] {
    FUNC_AND  = 4'd0,
    FUNC_OR   = 4'd1,
    FUNC_XOR  = 4'd2,
    FUNC_NOT  = 4'd3,
    FUNC_ADDI = 4'd4,
    FUNC_ADD  = 4'd5,
    FUNC_SUB  = 4'd6,
    FUNC_SLL  = 4'd7,
    FUNC_SLLI = 4'd8,
    FUNC_SLR  = 4'd9,
    FUNC_SLRI = 4'd10
  } func_t;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_t;

endpackage

// File: rtl/exec_shifter.sv
// Logical, zero-filling barrel shifter used by the execute stage.
module exec_shifter
  import simple_processor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]  operand_i,
  input  logic [SHAMT_WIDTH-1:0] amount_i,
  input  shift_dir_t             dir_i,
  output logic [DATA_WIDTH-1:0]  result_o
);

  // Shift in the selected direction; an unknown direction yields zero.
  always_comb begin
    result_o = '0;
    case (dir_i)
      SHIFT_LEFT:  result_o = operand_i << amount_i;
      SHIFT_RIGHT: result_o = operand_i >> amount_i;
      default:     result_o = '0;
    endcase
  end

endmodule

// File: rtl/merge_execution.sv
// Execute stage: logic, arithmetic and shift units in parallel, a merged
// result, and a registered copy of the merged result.
module merge_execution
  import simple_processor_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  arst_ni,
  input  logic [DATA_WIDTH-1:0] rs1_data_i,
  input  logic [DATA_WIDTH-1:0] rs2_data_i,
  input  logic [IMM_WIDTH-1:0]  imm,
  input  func_t                 func_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [DATA_WIDTH-1:0] res_math,
  output logic [DATA_WIDTH-1:0] res_shift,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] result_q_o
);

  logic [DATA_WIDTH-1:0]  imm_ext;
  logic [SHAMT_WIDTH-1:0] shift_amt;
  shift_dir_t             shift_dir;
  logic                   shift_en;
  logic [DATA_WIDTH-1:0]  shifter_out;

  assign imm_ext = {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};

  // Logic unit: bitwise ops, zero outside its class (and for unknown codes).
  always_comb begin
    rd_data_o = '0;
    case (func_i)
      FUNC_AND: rd_data_o = rs1_data_i & rs2_data_i;
      FUNC_OR:  rd_data_o = rs1_data_i | rs2_data_i;
      FUNC_XOR: rd_data_o = rs1_data_i ^ rs2_data_i;
      FUNC_NOT: rd_data_o = ~rs1_data_i;
      default:  rd_data_o = '0;
    endcase
  end

  // Arithmetic unit: modulo-2^DATA_WIDTH add/sub, carry discarded.
  always_comb begin
    res_math = '0;
    case (func_i)
      FUNC_ADD:  res_math = rs1_data_i + rs2_data_i;
      FUNC_ADDI: res_math = rs1_data_i + imm_ext;
      FUNC_SUB:  res_math = rs1_data_i - rs2_data_i;
      default:   res_math = '0;
    endcase
  end

  // Shift control: pick amount source and direction; upper amount bits dropped.
  always_comb begin
    shift_amt = '0;
    shift_dir = SHIFT_LEFT;
    shift_en  = 1'b0;
    case (func_i)
      FUNC_SLL: begin
        shift_amt = rs2_data_i[SHAMT_WIDTH-1:0];
        shift_en  = 1'b1;
      end
      FUNC_SLLI: begin
        shift_amt = imm[SHAMT_WIDTH-1:0];
        shift_en  = 1'b1;
      end
      FUNC_SLR: begin
        shift_amt = rs2_data_i[SHAMT_WIDTH-1:0];
        shift_dir = SHIFT_RIGHT;
        shift_en  = 1'b1;
      end
      FUNC_SLRI: begin
        shift_amt = imm[SHAMT_WIDTH-1:0];
        shift_dir = SHIFT_RIGHT;
        shift_en  = 1'b1;
      end
      default: begin
        shift_amt = '0;
        shift_dir = SHIFT_LEFT;
        shift_en  = 1'b0;
      end
    endcase
  end

  exec_shifter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shifter (
    .operand_i(rs1_data_i),
    .amount_i (shift_amt),
    .dir_i    (shift_dir),
    .result_o (shifter_out)
  );

  assign res_shift = shift_en ? shifter_out : '0;

  // Merge: select the unit owning func_i; undefined/unknown codes give zero.
  always_comb begin
    result = '0;
    case (func_i)
      FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_NOT:     result = rd_data_o;
      FUNC_ADDI, FUNC_ADD, FUNC_SUB:             result = res_math;
      FUNC_SLL, FUNC_SLLI, FUNC_SLR, FUNC_SLRI:  result = res_shift;
      default:                                   result = '0;
    endcase
  end

  // Pipeline boundary register for the merged result.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      result_q_o <= '0;
    end else begin
      result_q_o <= result;
    end
  end

endmodule

// File: tb/tb_merge_execution.sv
// Self-checking bench for merge_execution: directed table, randomized
// vectors against a reference model, and reset/register sequences.
module tb_merge_execution;
  import simple_processor_pkg::*;

  logic        clk_i;
  logic        arst_ni;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [5:0]  imm;
  func_t       func_i;
  logic [31:0] rd_data_o;
  logic [31:0] res_math;
  logic [31:0] res_shift;
  logic [31:0] result;
  logic [31:0] result_q_o;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  merge_execution #(
    .DATA_WIDTH(32)
  ) dut (
    .clk_i     (clk_i),
    .arst_ni   (arst_ni),
    .rs1_data_i(rs1_data_i),
    .rs2_data_i(rs2_data_i),
    .imm       (imm),
    .func_i    (func_i),
    .rd_data_o (rd_data_o),
    .res_math  (res_math),
    .res_shift (res_shift),
    .result    (result),
    .result_q_o(result_q_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [3:0]  func;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [5:0]  imm;
    logic [31:0] exp_logic;
    logic [31:0] exp_math;
    logic [31:0] exp_shift;
    logic [31:0] exp_result;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Reference model from the operation rules, using plain integer arithmetic.
  task automatic model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] im, output logic [31:0] l, output logic [31:0] m,
                       output logic [31:0] s, output logic [31:0] r);
    longint      sa, sb, si, tmp;
    longint unsigned scale;
    int unsigned amt;
    sa = longint'(a);
    sb = longint'(b);
    si = (im >= 6'd32) ? longint'(im) - 64 : longint'(im);
    l = 32'd0; m = 32'd0; s = 32'd0;
    case (f)
      4'd0: l = a & b;
      4'd1: l = a | b;
      4'd2: l = a ^ b;
      4'd3: l = 32'hFFFF_FFFF - a;
      4'd4: begin tmp = sa + si + 64'sd4294967296; m = 32'(tmp % 64'sd4294967296); end
      4'd5: begin tmp = sa + sb;                   m = 32'(tmp % 64'sd4294967296); end
      4'd6: begin tmp = sa - sb + 64'sd4294967296; m = 32'(tmp % 64'sd4294967296); end
      4'd7, 4'd8, 4'd9, 4'd10: begin
        amt   = (f == 4'd7 || f == 4'd9) ? (b % 32) : (int'(im) % 32);
        scale = 64'd1;
        for (int unsigned k = 0; k < amt; k++) scale = scale * 2;
        if (f == 4'd7 || f == 4'd8) s = 32'((longint'(a) * scale) % 64'd4294967296);
        else                        s = 32'(longint'(a) / scale);
      end
      default: ;
    endcase
    r = l | m | s;
  endtask

  task automatic drive(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] im);
    func_i     = func_t'(f);
    rs1_data_i = a;
    rs2_data_i = b;
    imm        = im;
  endtask

  vec_t vecs[17];

  initial begin
    logic [31:0] el, em, es, er, prev;
    logic [3:0]  f;
    logic [31:0] a, b;
    logic [5:0]  im;

    vecs[0]  = '{"and",     4'd0,  32'hA5A5A5A5, 32'h5A5A5A5A, 6'h15, 32'h0,        32'h0,        32'h0, 32'h0};
    vecs[1]  = '{"or",      4'd1,  32'hA5A5A5A5, 32'h5A5A5A5A, 6'h15, 32'hFFFFFFFF, 32'h0,        32'h0, 32'hFFFFFFFF};
    vecs[2]  = '{"xor",     4'd2,  32'hA5A5A5A5, 32'h5A5A5A5A, 6'h15, 32'hFFFFFFFF, 32'h0,        32'h0, 32'hFFFFFFFF};
    vecs[3]  = '{"not",     4'd3,  32'hA5A5A5A5, 32'h5A5A5A5A, 6'h15, 32'h5A5A5A5A, 32'h0,        32'h0, 32'h5A5A5A5A};
    vecs[4]  = '{"addi",    4'd4,  32'h1,        32'h7,        6'h03, 32'h0,        32'h4,        32'h0, 32'h4};
    vecs[5]  = '{"add",     4'd5,  32'h1,        32'h1,        6'h09, 32'h0,        32'h2,        32'h0, 32'h2};
    vecs[6]  = '{"sub",     4'd6,  32'h1,        32'h1,        6'h09, 32'h0,        32'h0,        32'h0, 32'h0};
    vecs[7]  = '{"sub_wrap",4'd6,  32'h0,        32'h1,        6'h00, 32'h0,        32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF};
    vecs[8]  = '{"addi_neg",4'd4,  32'h10,       32'h0,        6'h3F, 32'h0,        32'hF,        32'h0, 32'hF};
    vecs[9]  = '{"sll",     4'd7,  32'h1,        32'h2,        6'h05, 32'h0,        32'h0,        32'h4, 32'h4};
    vecs[10] = '{"slli",    4'd8,  32'h1,        32'h9,        6'h02, 32'h0,        32'h0,        32'h4, 32'h4};
    vecs[11] = '{"slr",     4'd9,  32'h4,        32'h2,        6'h05, 32'h0,        32'h0,        32'h1, 32'h1};
    vecs[12] = '{"slri",    4'd10, 32'h4,        32'h9,        6'h02, 32'h0,        32'h0,        32'h1, 32'h1};
    vecs[13] = '{"slr_msb", 4'd9,  32'h80000000, 32'd31,       6'h00, 32'h0,        32'h0,        32'h1, 32'h1};
    vecs[14] = '{"sll_33",  4'd7,  32'h1,        32'd33,       6'h00, 32'h0,        32'h0,        32'h2, 32'h2};
    vecs[15] = '{"slri_3f", 4'd10, 32'hFFFFFFFF, 32'h0,        6'h3F, 32'h0,        32'h0,        32'h1, 32'h1};
    vecs[16] = '{"undef12", 4'd12, 32'hDEADBEEF, 32'h12345678, 6'h2A, 32'h0,        32'h0,        32'h0, 32'h0};

    // Reset held: register stays cleared across edges with a nonzero result.
    arst_ni = 1'b0;
    drive(4'd5, 32'd3, 32'd4, 6'd0);
    repeat (3) @(posedge clk_i);
    #1 check("q_in_reset", result_q_o, 32'h0);
    drive(4'd3, 32'h0, 32'h0, 6'd0);
    @(posedge clk_i);
    #1 check("q_in_reset2", result_q_o, 32'h0);

    // Directed table (combinational, independent of the clock).
    foreach (vecs[i]) begin
      drive(vecs[i].func, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      #1;
      check({vecs[i].name, ".rd"},     rd_data_o, vecs[i].exp_logic);
      check({vecs[i].name, ".math"},   res_math,  vecs[i].exp_math);
      check({vecs[i].name, ".shift"},  res_shift, vecs[i].exp_shift);
      check({vecs[i].name, ".result"}, result,    vecs[i].exp_result);
    end

    // Release reset, ADD 3+4 lands in the register one edge later.
    @(negedge clk_i);
    arst_ni = 1'b1;
    drive(4'd5, 32'd3, 32'd4, 6'd0);
    @(posedge clk_i);
    #1 check("q_add", result_q_o, 32'h7);

    // Asynchronous reset between edges clears immediately.
    @(negedge clk_i);
    #2 arst_ni = 1'b0;
    #1 check("q_async_clr", result_q_o, 32'h0);
    check("comb_unaffected", result, 32'h7);
    @(negedge clk_i);
    arst_ni = 1'b1;

    // Randomized vectors with registered-output tracking.
    prev = 32'h0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk_i);
      f  = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 70)) : $urandom;
      im = 6'($urandom);
      drive(f, a, b, im);
      model(f, a, b, im, el, em, es, er);
      #1;
      check("rnd.rd",     rd_data_o, el);
      check("rnd.math",   res_math,  em);
      check("rnd.shift",  res_shift, es);
      check("rnd.result", result,    er);
      @(posedge clk_i);
      #1 check("rnd.q", result_q_o, er);
      prev = er;
    end

    // Register holds last result until the next edge.
    @(negedge clk_i);
    drive(4'd1, 32'h0F0F0000, 32'h0000F0F0, 6'd0);
    #1 check("q_hold", result_q_o, prev);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/merge_execution.md
# merge_execution

Combinational execute stage of the simple processor. Takes two register operands, a 6-bit immediate and a decoded function code, and computes the logic, arithmetic and shift results in parallel. It presents each unit's output separately and also as one merged `result`. A registered copy of `result` is provided for the pipeline boundary.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: operand and result width.

Ports:
- `clk_i`, input, 1: clock; only the `result_q_o` register uses it.
- `arst_ni`, input, 1: reset, asynchronous, active-low.
- `rs1_data_i`, input, DATA_WIDTH: source operand 1.
- `rs2_data_i`, input, DATA_WIDTH: source operand 2.
- `imm`, input, 6: immediate, two's complement.
- `func_i`, input, `func_t`: operation select.
- `rd_data_o`, output, DATA_WIDTH: logic-unit result.
- `res_math`, output, DATA_WIDTH: arithmetic-unit result.
- `res_shift`, output, DATA_WIDTH: shift-unit result.
- `result`, output, DATA_WIDTH: merged result for `func_i`.
- `result_q_o`, output, DATA_WIDTH: `result` registered on `clk_i`.

## Operation
- `imm_ext` = `imm` sign-extended to DATA_WIDTH.
- Logic unit drives `rd_data_o`:
  - AND: rs1 & rs2
  - OR: rs1 | rs2
  - XOR: rs1 ^ rs2
  - NOT: ~rs1 (rs2 ignored)
  - any other func: 0
- Arithmetic unit drives `res_math`, modulo 2^DATA_WIDTH, carry/overflow discarded, no flags:
  - ADD: rs1 + rs2
  - ADDI: rs1 + imm_ext
  - SUB: rs1 − rs2
  - any other func: 0
- Shift unit drives `res_shift`. Shifts are logical and zero-fill.
  - SLL: rs1 << rs2[4:0]
  - SLLI: rs1 << imm[4:0]
  - SLR: rs1 >> rs2[4:0]
  - SLRI: rs1 >> imm[4:0]
  - any other func: 0
  - Upper bits of the shift amount are ignored. rs2 = 33 shifts by 1; imm = 6'h3F shifts by 31.
- `result` is `rd_data_o` for logic ops, `res_math` for arithmetic ops, `res_shift` for shift ops, and 0 for undefined `func_i` codes. Because each unit outputs 0 outside its class, `result` equals the OR of the three unit outputs.
- Undefined or unknown `func_i` codes: all outputs are 0; X must not propagate.

## Timing
- `rd_data_o`, `res_math`, `res_shift` and `result` are purely combinational from the inputs: zero-cycle latency, no clock dependency.
- `result_q_o`:
  - Cleared to 0 asynchronously while `arst_ni` = 0.
  - After reset release, loads `result` on every rising edge of `clk_i`: one-cycle latency, no enable.
- Reset has no effect on the combinational outputs. Assertion during operation clears only `result_q_o`, immediately.
- No handshake. Every input change is reflected on the combinational outputs within the same delta cycle.

## Structure
- `simple_processor_pkg` owns `func_t`, a 4-bit enum. The package already defines it for the decoder; if not, use encodings in this order: AND=0, OR=1, XOR=2, NOT=3, ADDI=4, ADD=5, SUB=6, SLL=7, SLLI=8, SLR=9, SLRI=10. Codes 11–15 are undefined.
- `DATA_WIDTH` default and the immediate width (6) also live in the package.
- The three units are always-comb blocks inside `merge_execution`. Sub-module `exec_shifter` (operand, 5-bit amount, direction → result) is natural and may be split out; the logic and arithmetic units stay inline.

## Test plan
- Logic ops, rs1=A5A5A5A5, rs2=5A5A5A5A:
  - AND → rd_data_o=00000000
  - OR → FFFFFFFF
  - XOR → FFFFFFFF
  - NOT → 5A5A5A5A
  - In each case `result` equals `rd_data_o`, and `res_math` = `res_shift` = 0.
- Arithmetic ops:
  - rs1=1, imm=6'b000011, ADDI → res_math=00000004.
  - rs1=1, rs2=1: ADD → 00000002; SUB → 00000000.
  - rs1=0, rs2=1, SUB → FFFFFFFF (wrap).
  - rs1=10, imm=6'h3F, ADDI → 0000000F (negative immediate).
- Shift ops:
  - rs1=1, rs2=2, SLL → res_shift=00000004.
  - rs1=1, imm=2, SLLI → 00000004.
  - rs1=4, rs2=2, SLR → 00000001.
  - rs1=4, imm=2, SLRI → 00000001.
  - rs1=80000000, rs2=31, SLR → 00000001 (no sign fill).
- Shift-amount truncation:
  - rs1=1, rs2=33, SLL → 00000002.
  - rs1=FFFFFFFF, imm=6'h3F, SLRI → 00000001.
- Undefined `func_i`=4'd12 with nonzero operands → all four combinational outputs are 0.
- Registered output:
  - Hold `arst_ni`=0 → result_q_o=0 regardless of clock or inputs.
  - Release reset, apply ADD with 3+4 → result_q_o=00000007 after the next rising edge of `clk_i`.
  - Assert reset asynchronously between edges → result_q_o clears immediately.
